policy_deck: RTL

POLICY_DECK -- requirements
Module: policy_deck

---
 rtl/snpu_pkg.sv | 28 ++
 rtl/policy_lfsr.sv | 18 +
 rtl/policy_deck.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/snpu_pkg.sv
// Shared opcodes, deck constants, FSM states and LFSR step for the policy deck.
package snpu_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_NEW_GAME = 3'd1,
    OP_DRAW3    = 3'd2,
    OP_DISCARD  = 3'd3,
    OP_ENACT    = 3'd4,
    OP_TOPDECK  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHUF,
    DRAW
  } state_e;

  localparam int          FULL_DECK  = 17;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/policy_lfsr.sv
// Free-running 16-bit Galois LFSR; a zero seed falls back to the reset value.
module policy_lfsr
  import snpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst)       state <= LFSR_RESET;
    else if (load) state <= (seed == '0) ? LFSR_RESET : seed;
    else           state <= lfsr_step(state);
  end

endmodule

// File: rtl/policy_deck.sv
// Policy card deck: count-based draw/discard piles, a 3-slot hand and the board,
// with draws made by rejection sampling on the LFSR.
module policy_deck
  import snpu_pkg::*;
#(
  parameter int NUM_LIB = 6,
  parameter int NUM_FAS = FULL_DECK - 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_idx,
  input  logic [15:0] seed,
  output logic        cmd_ready,
  output logic        op_done,
  output logic        cmd_err,
  output logic [2:0]  hand_valid,
  output logic [2:0]  hand_card,
  output logic [2:0]  board_lib,
  output logic [2:0]  board_fas,
  output logic [4:0]  draw_n,
  output logic [4:0]  discard_n,
  output logic        lib_win,
  output logic        fas_win
);

  localparam logic [4:0] INIT_LIB = 5'(NUM_LIB);
  localparam logic [4:0] INIT_FAS = 5'(NUM_FAS);

  state_e      state;
  op_e         op;
  logic        to_board;
  logic [1:0]  slot;
  logic [4:0]  draw_lib, draw_fas, disc_lib, disc_fas;
  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic [4:0]  r;
  logic        hit, hit_lib, accept, legal;
  logic [2:0]  sel, other;
  logic        sel_lib, other_lib, two_valid, idx_ok;

  policy_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept && op == OP_NEW_GAME),
    .seed (seed),
    .state(lfsr)
  );

  assign lfsr_unused = ^lfsr[15:5];
  assign op          = op_e'(cmd_op);
  assign cmd_ready   = (state == IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign draw_n      = draw_lib + draw_fas;
  assign discard_n   = disc_lib + disc_fas;
  assign lib_win     = (board_lib == 3'd5);
  assign fas_win     = (board_fas == 3'd6);

  assign r         = lfsr[4:0];
  assign hit       = (r < draw_n);
  assign hit_lib   = (r < draw_lib);
  assign sel       = 3'b001 << cmd_idx;
  assign other     = hand_valid & ~sel;
  assign sel_lib   = |(sel & hand_card);
  assign other_lib = |(other & hand_card);
  assign idx_ok    = (cmd_idx != 2'd3);
  assign two_valid = (hand_valid == 3'b011) || (hand_valid == 3'b101) ||
                     (hand_valid == 3'b110);

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_NOP, OP_NEW_GAME:  legal = 1'b1;
      OP_DRAW3, OP_TOPDECK: legal = (hand_valid == '0) && !lib_win && !fas_win;
      OP_DISCARD:           legal = (hand_valid == '1) && idx_ok;
      OP_ENACT:             legal = two_valid && idx_ok && |(sel & hand_valid);
      default:              legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      to_board   <= 1'b0;
      slot       <= '0;
      draw_lib   <= INIT_LIB;
      draw_fas   <= INIT_FAS;
      disc_lib   <= '0;
      disc_fas   <= '0;
      board_lib  <= '0;
      board_fas  <= '0;
      hand_valid <= '0;
      hand_card  <= '0;
      op_done    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      op_done <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (!legal) begin
            cmd_err <= 1'b1;
          end else begin
            case (op)
              OP_NEW_GAME: begin
                draw_lib   <= INIT_LIB;
                draw_fas   <= INIT_FAS;
                disc_lib   <= '0;
                disc_fas   <= '0;
                board_lib  <= '0;
                board_fas  <= '0;
                hand_valid <= '0;
                op_done    <= 1'b1;
              end
              OP_DRAW3: begin
                to_board <= 1'b0;
                slot     <= '0;
                state    <= (draw_n < 5'd3) ? SHUF : DRAW;
              end
              OP_TOPDECK: begin
                to_board <= 1'b1;
                state    <= (draw_n == '0) ? SHUF : DRAW;
              end
              OP_DISCARD: begin
                hand_valid <= hand_valid & ~sel;
                if (sel_lib) disc_lib <= disc_lib + 5'd1;
                else         disc_fas <= disc_fas + 5'd1;
                op_done <= 1'b1;
              end
              OP_ENACT: begin
                hand_valid <= '0;
                if (sel_lib)   board_lib <= board_lib + 3'd1;
                else           board_fas <= board_fas + 3'd1;
                if (other_lib) disc_lib  <= disc_lib + 5'd1;
                else           disc_fas  <= disc_fas + 5'd1;
                op_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        SHUF: begin
          draw_lib <= draw_lib + disc_lib;
          draw_fas <= draw_fas + disc_fas;
          disc_lib <= '0;
          disc_fas <= '0;
          state    <= DRAW;
        end
        DRAW: if (hit) begin
          if (hit_lib) draw_lib <= draw_lib - 5'd1;
          else         draw_fas <= draw_fas - 5'd1;
          if (to_board) begin
            if (hit_lib) board_lib <= board_lib + 3'd1;
            else         board_fas <= board_fas + 3'd1;
            state   <= IDLE;
            op_done <= 1'b1;
          end else begin
            hand_valid[slot] <= 1'b1;
            hand_card[slot]  <= hit_lib;
            slot             <= slot + 2'd1;
            if (slot == 2'd2) begin
              state   <= IDLE;
              op_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
